nr_denominator_normalizer: RTL and testbench

Sequential front-end stage for the Q16.16 Newton-Raphson divider. It accepts a 64-bit unsigned denominator over a valid/ready handshake and shifts it one bit per cycle into the normalized range [0.5, 1.0), i.e. raw value 32768..65535. It outputs:

- the normalized value,
- the signed shift count,
- the 6-bit seed-table index consumed by the divider stage,
- a divide-by-zero flag.

---
 rtl/nr_denominator_normalizer_pkg.sv | 23 ++
 rtl/nr_denominator_normalizer.sv | 107 ++++++++++
 tb/tb_nr_denominator_normalizer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/nr_denominator_normalizer_pkg.sv
// Shared definitions for the Q16.16 Newton-Raphson divider front end.
// The normalizer, the divider stage and the seed table all use this package:
//   - Q16.16 constants: Q_ONE (1.0), Q_HALF (0.5), IDX_SHIFT (seed index shift)
//   - default datapath widths
//   - normalizer FSM state encoding
package nr_denominator_normalizer_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int SHIFT_W_DEF = 16;
  localparam int IDX_W_DEF   = 6;

  localparam int unsigned Q_ONE     = 32'd65536;
  localparam int unsigned Q_HALF    = 32'd32768;
  localparam int unsigned IDX_SHIFT = 32'd9;

  typedef enum logic [1:0] {
    IDLE,
    CHECK_ZERO,
    SHIFT,
    DONE
  } nrm_state_e;

endpackage

// File: rtl/nr_denominator_normalizer.sv
// Sequential denominator normalizer.
// Accepts an unsigned Q16.16 denominator and shifts it one bit per cycle into
// [0.5, 1.0) (raw 32768..65535). It reports the normalized value, the signed
// net shift count, the 6-bit seed-table index and a divide-by-zero flag.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake, in_denom = operand
//   out_valid/out_ready   result handshake
//   out_norm              normalized value (0 on divide-by-zero)
//   out_shifts            signed net shift (+ left, - right)
//   out_index             (out_norm - 0.5) >> 9, truncated to IDX_W bits
//   out_dbz               operand was zero
module nr_denominator_normalizer
  import nr_denominator_normalizer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_denom,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_norm,
  output logic signed [SHIFT_W-1:0] out_shifts,
  output logic [IDX_W-1:0]          out_index,
  output logic                      out_dbz
);

  localparam logic [DATA_W-1:0] HALF = DATA_W'(Q_HALF);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(Q_ONE);

  nrm_state_e                state_q, state_d;
  logic [DATA_W-1:0]         work_q;
  logic signed [SHIFT_W-1:0] cnt_q;
  logic                      zero_q;
  logic                      in_range;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign in_range  = (work_q >= HALF) && (work_q < ONE);

  // A zero result (and the reset value 0) lies below 0.5; without the guard the
  // subtraction would wrap and yield a nonzero index.
  assign out_index = (out_norm >= HALF) ? IDX_W'((out_norm - HALF) >> IDX_SHIFT)
                                        : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (in_valid) state_d = CHECK_ZERO;
      CHECK_ZERO: state_d = SHIFT;
      // A zero operand still passes through SHIFT once so it finalizes in the
      // same slot as an already-normalized operand (uniform 2-cycle minimum).
      SHIFT:      if (zero_q || in_range) state_d = DONE;
      DONE:       if (out_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q     <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      out_norm   <= '0;
      out_shifts <= '0;
      out_dbz    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          work_q <= in_denom;
          cnt_q  <= '0;
          zero_q <= 1'b0;
        end
        CHECK_ZERO: zero_q <= (work_q == '0);
        SHIFT: begin
          if (zero_q) begin
            out_norm   <= '0;
            out_shifts <= '0;
            out_dbz    <= 1'b1;
          end else if (work_q < HALF) begin
            work_q <= work_q << 1;
            cnt_q  <= cnt_q + SHIFT_W'(1);
          end else if (work_q >= ONE) begin
            work_q <= work_q >> 1;  // logical; shifted-out bits are dropped
            cnt_q  <= cnt_q - SHIFT_W'(1);
          end else begin
            out_norm   <= work_q;
            out_shifts <= cnt_q;
            out_dbz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_denominator_normalizer.sv
module tb_nr_denominator_normalizer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        in_denom;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_norm;
  logic signed [15:0] out_shifts;
  logic [5:0]         out_index;
  logic               out_dbz;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nr_denominator_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_denom  (in_denom),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_norm  (out_norm),
    .out_shifts(out_shifts),
    .out_index (out_index),
    .out_dbz   (out_dbz)
  );

  // Present one operand, then count edges from the accept edge until out_valid.
  // The result is left pending; out_ready decides whether it drains.
  task automatic start_op(input logic [63:0] d, output int lat);
    @(negedge clk);
    in_denom = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic drain;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_denom = '0; out_ready = 1'b1;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_norm !== 64'd0 || out_shifts !== 16'sd0 || out_index !== 6'd0 || out_dbz !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs got norm=%0d sh=%0d idx=%0d dbz=%b want 0s", out_norm, out_shifts, out_index, out_dbz);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int lat;
    // 23 -> 23<<11 = 47104, index (47104-32768)>>9 = 28
    start_op(64'd23, lat);
    n_cmp++; if (lat !== 13) begin n_err++; $display("FAIL lat_23 got %0d want 13", lat); end
    n_cmp++; if (out_norm !== 64'd47104) begin n_err++; $display("FAIL norm_23 got %0d want 47104", out_norm); end
    n_cmp++; if (out_shifts !== 16'sd11) begin n_err++; $display("FAIL shifts_23 got %0d want 11", out_shifts); end
    n_cmp++; if (out_index !== 6'd28 || out_dbz !== 1'b0) begin n_err++; $display("FAIL idx_23 got idx=%0d dbz=%b want 28/0", out_index, out_dbz); end
    drain();
    // 1.0 -> one right shift
    start_op(64'd65536, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL lat_one got %0d want 3", lat); end
    n_cmp++; if (out_norm !== 64'd32768 || out_shifts !== -16'sd1 || out_index !== 6'd0) begin
      n_err++; $display("FAIL one got norm=%0d sh=%0d idx=%0d want 32768/-1/0", out_norm, out_shifts, out_index);
    end
    drain();
    // already normalized: 7232>>9 = 14
    start_op(64'd40000, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL lat_40000 got %0d want 2", lat); end
    n_cmp++; if (out_norm !== 64'd40000 || out_shifts !== 16'sd0 || out_index !== 6'd14) begin
      n_err++; $display("FAIL v40000 got norm=%0d sh=%0d idx=%0d want 40000/0/14", out_norm, out_shifts, out_index);
    end
    drain();
  endtask

  task automatic test_boundaries;
    int lat;
    start_op(64'd0, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL lat_zero got %0d want 2", lat); end
    n_cmp++; if (out_dbz !== 1'b1 || out_norm !== 64'd0 || out_shifts !== 16'sd0 || out_index !== 6'd0) begin
      n_err++; $display("FAIL zero got dbz=%b norm=%0d sh=%0d idx=%0d want 1/0/0/0", out_dbz, out_norm, out_shifts, out_index);
    end
    drain();
    start_op(64'hFFFF_FFFF_FFFF_FFFF, lat);
    n_cmp++; if (lat !== 50) begin n_err++; $display("FAIL lat_max got %0d want 50", lat); end
    n_cmp++; if (out_norm !== 64'd65535 || out_shifts !== -16'sd48 || out_index !== 6'd63 || out_dbz !== 1'b0) begin
      n_err++; $display("FAIL max got norm=%0d sh=%0d idx=%0d dbz=%b want 65535/-48/63/0", out_norm, out_shifts, out_index, out_dbz);
    end
    drain();
  endtask

  task automatic test_backpressure;
    int lat;
    logic stable;
    out_ready = 1'b0;
    start_op(64'd23, lat);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", out_valid); end
    stable = 1'b1;
    // a competing operand while busy must be ignored
    in_valid = 1'b1; in_denom = 64'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_norm !== 64'd47104 ||
          out_shifts !== 16'sd11 || out_index !== 6'd28 || out_dbz !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL bp_hold got unstable want stable norm=%0d sh=%0d", out_norm, out_shifts); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    start_op(64'd1, lat);
    n_cmp++; if (out_norm !== 64'd32768 || out_shifts !== 16'sd15 || lat !== 17) begin
      n_err++; $display("FAIL bp_second got norm=%0d sh=%0d lat=%0d want 32768/15/17", out_norm, out_shifts, lat);
    end
    drain();
  endtask

  task automatic test_reset_midshift;
    int lat;
    @(negedge clk); in_denom = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    start_op(64'd23, lat);
    n_cmp++; if (out_norm !== 64'd47104 || out_shifts !== 16'sd11 || lat !== 13) begin
      n_err++; $display("FAIL rst_after got norm=%0d sh=%0d lat=%0d want 47104/11/13", out_norm, out_shifts, lat);
    end
    drain();
  endtask

  task automatic test_random_sweep;
    int lat, k;
    logic [63:0] d, exp;
    for (int i = 0; i < 1000; i++) begin
      d = {$urandom, $urandom} >> $urandom_range(63, 0);
      if (d == 64'd0) d = 64'd1;
      start_op(d, lat);
      k = int'(out_shifts);
      exp = (k > 0) ? (d << k) : (d >> (-k));
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rnd_timeout d=%h got valid=%b want 1", d, out_valid); end
      n_cmp++; if (out_norm < 64'd32768 || out_norm > 64'd65535) begin n_err++; $display("FAIL rnd_range d=%h got %0d want 32768..65535", d, out_norm); end
      n_cmp++; if (out_norm !== exp) begin n_err++; $display("FAIL rnd_shift d=%h k=%0d got %0d want %0d", d, k, out_norm, exp); end
      n_cmp++; if (out_index !== 6'((out_norm - 64'd32768) >> 9)) begin n_err++; $display("FAIL rnd_index d=%h got %0d norm %0d", d, out_index, out_norm); end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_backpressure();
    test_reset_midshift();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
